// File: rtl/conv_ch_serializer.sv
// Buffers parallel channel vectors in a small FIFO and streams them out one word per cycle.
// Optional build macro RELU_EN clamps words with the sign bit set to zero at the output.
module conv_ch_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int CH         = 32,
    parameter int DEPTH      = 4,
    parameter int OUT_DIM    = 147
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic [CH*DATA_WIDTH-1:0] pxl_in,
    input  logic                     ready_in,
    output logic [DATA_WIDTH-1:0]    pxl_out,
    output logic [$clog2(CH)-1:0]    ch_idx,
    output logic                     last_ch,
    output logic                     valid_out,
    output logic                     full,
    output logic                     overflow,
    output logic                     frame_done
);

    localparam int CW    = $clog2(CH);
    localparam int AW    = $clog2(DEPTH);
    localparam int NW    = $clog2(DEPTH + 1);
    localparam int FRAME = OUT_DIM * OUT_DIM;
    localparam int PW    = (FRAME > 1) ? $clog2(FRAME) : 1;

    logic [CH-1:0][DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [PW-1:0] pix_q, pix_d;
    logic          ovf_q, ovf_d;
    logic          fdone_q, fdone_d;

    logic                  push;
    logic                  xfer;
    logic                  pop;
    logic [DATA_WIDTH-1:0] word;

    assign full       = (count_q == NW'(DEPTH));
    assign valid_out  = (count_q != '0);
    assign ch_idx     = ch_q;
    assign last_ch    = valid_out && (ch_q == CW'(CH - 1));
    assign overflow   = ovf_q;
    assign frame_done = fdone_q;

    always_comb begin
        word = mem_q[rd_ptr_q][ch_q];
`ifdef RELU_EN
        pxl_out = (valid_out && !word[DATA_WIDTH-1]) ? word : '0;
`else
        pxl_out = valid_out ? word : '0;
`endif
    end

    // A write is judged against the pre-edge count, so a pop in the same cycle cannot rescue it.
    always_comb begin
        push     = valid_in && !full;
        xfer     = valid_out && ready_in;
        pop      = xfer && (ch_q == CW'(CH - 1));
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        ovf_d    = ovf_q || (valid_in && full);
        ch_d     = ch_q;
        pix_d    = pix_q;
        fdone_d  = 1'b0;
        count_d  = count_q;
        if (xfer) begin
            ch_d = pop ? '0 : ch_q + 1'b1;
        end
        if (pop) begin
            if (pix_q == PW'(FRAME - 1)) begin
                pix_d   = '0;
                fdone_d = 1'b1;
            end else begin
                pix_d = pix_q + 1'b1;
            end
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pxl_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ch_q     <= '0;
            pix_q    <= '0;
            ovf_q    <= 1'b0;
            fdone_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ch_q     <= ch_d;
            pix_q    <= pix_d;
            ovf_q    <= ovf_d;
            fdone_q  <= fdone_d;
        end
    end

endmodule

// File: tb/tb_conv_ch_serializer.sv
// Directed bench for conv_ch_serializer with DEPTH=4 and a 3x3 frame.
// Expected RELU results follow the RELU_EN macro of the build.
module tb_conv_ch_serializer;

    typedef struct {
        logic        validIn;
        logic        readyIn;
        logic [31:0] base;
        logic        expValid;
        logic [4:0]  expCh;
        logic        expLast;
        logic [31:0] expWord;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [1023:0] pxl_in;
    logic          ready_in;
    logic [31:0]   pxl_out;
    logic [4:0]    ch_idx;
    logic          last_ch;
    logic          valid_out;
    logic          full;
    logic          overflow;
    logic          frame_done;

    int compared   = 0;
    int mismatched = 0;

    conv_ch_serializer #(
        .DATA_WIDTH(32),
        .CH(32),
        .DEPTH(4),
        .OUT_DIM(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .valid_in(valid_in),
        .pxl_in(pxl_in),
        .ready_in(ready_in),
        .pxl_out(pxl_out),
        .ch_idx(ch_idx),
        .last_ch(last_ch),
        .valid_out(valid_out),
        .full(full),
        .overflow(overflow),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [1023:0] makeVec(input logic [31:0] base);
        logic [1023:0] v;
        for (int k = 0; k < 32; k++) v[k*32 +: 32] = base + 32'(k);
        return v;
    endfunction

    task automatic applyStimulus(input logic v, input logic r, input logic [1023:0] p);
        valid_in = v;
        ready_in = r;
        pxl_in   = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t          vecs [33];
        logic [1023:0] v;
        logic [31:0]   e0, e1, e2;
        int            idx, words, pulses;

        // Reset state
        reset = 1'b1;
        applyStimulus(0, 0, '0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", valid_out, 0);
        checkOutput("rst_pxl", pxl_out, 0);
        checkOutput("rst_ch", ch_idx, 0);
        checkOutput("rst_last", last_ch, 0);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_ovf", overflow, 0);
        checkOutput("rst_fdone", frame_done, 0);
        reset = 1'b0;

        // Partial drain then asynchronous reset
        applyStimulus(1, 1, makeVec(32'h500));
        tick();
        applyStimulus(0, 1, '0);
        checkOutput("ld_valid", valid_out, 1);
        checkOutput("ld_ch", ch_idx, 0);
        repeat (10) tick();
        checkOutput("mid_ch", ch_idx, 10);
        checkOutput("mid_pxl", pxl_out, 32'h50A);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_valid", valid_out, 0);
        checkOutput("async_ch", ch_idx, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        checkOutput("post_full", full, 0);
        checkOutput("post_ch", ch_idx, 0);
        checkOutput("post_valid", valid_out, 0);

        // Single vector, table driven
        vecs[0] = '{1'b1, 1'b1, 32'h100, 1'b1, 5'd0, 1'b0, 32'h100};
        for (int i = 1; i < 32; i++)
            vecs[i] = '{1'b0, 1'b1, 32'h0, 1'b1, 5'(i), (i == 31), 32'h100 + 32'(i)};
        vecs[32] = '{1'b0, 1'b1, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0};
        for (int i = 0; i < 33; i++) begin
            applyStimulus(vecs[i].validIn, vecs[i].readyIn, makeVec(vecs[i].base));
            tick();
            checkOutput($sformatf("single_valid[%0d]", i), valid_out, vecs[i].expValid);
            checkOutput($sformatf("single_ch[%0d]", i), ch_idx, vecs[i].expCh);
            checkOutput($sformatf("single_last[%0d]", i), last_ch, vecs[i].expLast);
            checkOutput($sformatf("single_pxl[%0d]", i), pxl_out, vecs[i].expWord);
        end

        // Backpressure with alternating ready
        applyStimulus(1, 0, makeVec(32'h200));
        tick();
        applyStimulus(1, 0, makeVec(32'h300));
        tick();
        applyStimulus(0, 0, '0);
        idx = 0;
        for (int cyc = 0; cyc < 300 && idx < 64; cyc++) begin
            ready_in = (cyc % 2 == 0);
            checkOutput("bp_valid", valid_out, 1);
            checkOutput($sformatf("bp_pxl[%0d]", idx), pxl_out,
                        (idx < 32) ? 32'h200 + 32'(idx) : 32'h300 + 32'(idx - 32));
            checkOutput("bp_ch", ch_idx, 32'(idx % 32));
            tick();
            if (ready_in) idx++;
        end
        checkOutput("bp_words", idx, 64);
        checkOutput("bp_empty", valid_out, 0);

        // Overflow: five vectors into a four-deep FIFO
        for (int n = 0; n < 5; n++) begin
            applyStimulus(1, 0, makeVec(32'h1000_0000 * 32'(n + 1)));
            tick();
            if (n == 2) checkOutput("ovf_notfull", full, 0);
            if (n == 3) begin
                checkOutput("ovf_full4", full, 1);
                checkOutput("ovf_clear4", overflow, 0);
            end
            if (n == 4) begin
                checkOutput("ovf_full5", full, 1);
                checkOutput("ovf_set", overflow, 1);
            end
        end
        applyStimulus(0, 1, '0);
        words = 0;
        for (int cyc = 0; cyc < 400 && valid_out; cyc++) begin
            checkOutput($sformatf("ovf_pxl[%0d]", words), pxl_out,
                        32'h1000_0000 * 32'(words / 32 + 1) + 32'(words % 32));
            words++;
            tick();
        end
        checkOutput("ovf_words", words, 128);
        checkOutput("ovf_sticky", overflow, 1);
        checkOutput("ovf_empty", valid_out, 0);
        reset = 1'b1;
        #2 reset = 1'b0;
        checkOutput("ovf_rst", overflow, 0);

        // Sign handling at the output
        v = makeVec(32'h700);
        v[31:0]  = 32'hBF80_0000;
        v[63:32] = 32'h3F80_0000;
        v[95:64] = 32'h8000_0000;
`ifdef RELU_EN
        e0 = 32'h0;
        e1 = 32'h3F80_0000;
        e2 = 32'h0;
`else
        e0 = 32'hBF80_0000;
        e1 = 32'h3F80_0000;
        e2 = 32'h8000_0000;
`endif
        applyStimulus(1, 1, v);
        tick();
        applyStimulus(0, 1, '0);
        checkOutput("relu_ch0", pxl_out, e0);
        tick();
        checkOutput("relu_ch1", pxl_out, e1);
        tick();
        checkOutput("relu_ch2", pxl_out, e2);
        for (int cyc = 0; cyc < 100 && valid_out; cyc++) tick();
        checkOutput("relu_empty", valid_out, 0);

        // Frame tracking over two 3x3 frames
        reset = 1'b1;
        #2 reset = 1'b0;
        pulses = 0;
        applyStimulus(1, 1, makeVec(32'h1_0000));
        for (int c = 0; c < 620; c++) begin
            tick();
            checkOutput($sformatf("frame_done[%0d]", c), frame_done, (c == 288 || c == 576));
            if (frame_done) pulses++;
            if ((c + 1) % 32 == 0 && (c + 1) / 32 < 18)
                applyStimulus(1, 1, makeVec(32'h1_0000 * 32'((c + 1) / 32 + 1)));
            else
                applyStimulus(0, 1, '0);
        end
        checkOutput("frame_pulses", pulses, 2);
        checkOutput("frame_empty", valid_out, 0);
        checkOutput("frame_ovf", overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
